// File: rtl/i2c_target.sv
// i2c_target: oversampled I2C responder. SCL/SDA are synchronised, glitch
// filtered and decoded entirely on clk. It matches a 7-bit address, ACKs and
// delivers write bytes, and serves read bytes via a byte handshake.
// Optional feature macro: I2C_CLK_STRETCH_EN (holds SCL low until tx_valid).
// Ports:
//   clk, rst_n            system clock, async active-low reset
//   scl, sda              open-drain I2C lines
//   rx_data/valid/first   received write byte, valid pulse, first-byte flag
//   tx_req/data/valid     read byte request, byte, ready (stretch build only)
//   busy, rw              matched-transfer flag and its R/W bit
//   start_det, stop_det   bus condition pulses
//   nack_det              master NACKed a read byte
module i2c_target #(
  parameter logic [6:0]  TARGET_ADDR = 7'h34,
  parameter int unsigned FILTER_LEN  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  inout  wire        scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_first,
  output logic       tx_req,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       busy,
  output logic       rw,
  output logic       start_det,
  output logic       stop_det,
  output logic       nack_det
);

  localparam int unsigned FCNT_W = 3;
  localparam int unsigned BCNT_W = 3;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ACK_ADDR, S_WRITE, S_ACK_WR, S_READ, S_ACK_RD, S_WAIT_STOP
  } state_t;

  // Input path: index 1 = SCL, index 0 = SDA. Idle bus level is high.
  logic [1:0]             meta, sync, filt, filt_q;
  logic [1:0][FCNT_W-1:0] fcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 2'b11;
      sync   <= 2'b11;
      filt   <= 2'b11;
      filt_q <= 2'b11;
      fcnt   <= '0;
    end else begin
      meta   <= {scl, sda};
      sync   <= meta;
      filt_q <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FCNT_W'(FILTER_LEN - 1)) begin
          filt[i] <= sync[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FCNT_W'(1);
        end
      end
    end
  end

  logic scl_rise_c, scl_fall_c, start_c, stop_c, sda_f;
  assign sda_f      = filt[0];
  assign scl_rise_c = filt[1] & ~filt_q[1];
  assign scl_fall_c = ~filt[1] & filt_q[1];
  assign start_c    = filt[1] & filt_q[1] & filt_q[0] & ~filt[0];
  assign stop_c     = filt[1] & filt_q[1] & ~filt_q[0] & filt[0];

  // tx_data acceptance: with stretching wait for tx_valid, SCL is held low
  // exactly while tx_req is pending.
  logic load_ok_c;
`ifdef I2C_CLK_STRETCH_EN
  assign load_ok_c = tx_valid;
  assign scl       = tx_req ? 1'b0 : 1'bz;
`else
  logic unused_tx_valid;
  assign unused_tx_valid = tx_valid;
  assign load_ok_c       = 1'b1;
  assign scl             = 1'bz;
`endif

  state_t            state, state_d;
  logic [BCNT_W-1:0] bit_cnt, bit_cnt_d;
  logic [7:0]        shift, shift_d, shift_in_c, rx_data_d;
  logic              ack_phase, ack_phase_d, sda_oe, sda_oe_d;
  logic              rx_pend, rx_pend_d, first_pend, first_pend_d;
  logic              rx_valid_d, rx_first_d, tx_req_d, busy_d, rw_d;
  logic              start_det_d, stop_det_d, nack_det_d;

  assign sda        = sda_oe ? 1'b0 : 1'bz;
  assign shift_in_c = {shift[6:0], sda_f};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      ack_phase  <= 1'b0;
      sda_oe     <= 1'b0;
      rx_pend    <= 1'b0;
      first_pend <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_first   <= 1'b0;
      tx_req     <= 1'b0;
      busy       <= 1'b0;
      rw         <= 1'b0;
      start_det  <= 1'b0;
      stop_det   <= 1'b0;
      nack_det   <= 1'b0;
    end else begin
      state      <= state_d;
      bit_cnt    <= bit_cnt_d;
      shift      <= shift_d;
      ack_phase  <= ack_phase_d;
      sda_oe     <= sda_oe_d;
      rx_pend    <= rx_pend_d;
      first_pend <= first_pend_d;
      rx_data    <= rx_data_d;
      rx_valid   <= rx_valid_d;
      rx_first   <= rx_first_d;
      tx_req     <= tx_req_d;
      busy       <= busy_d;
      rw         <= rw_d;
      start_det  <= start_det_d;
      stop_det   <= stop_det_d;
      nack_det   <= nack_det_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d      = state;
    bit_cnt_d    = bit_cnt;
    shift_d      = shift;
    ack_phase_d  = ack_phase;
    sda_oe_d     = sda_oe;
    rx_pend_d    = 1'b0;
    first_pend_d = first_pend;
    rx_data_d    = rx_data;
    rx_valid_d   = rx_pend;
    rx_first_d   = rx_pend & first_pend;
    tx_req_d     = 1'b0;
    busy_d       = busy;
    rw_d         = rw;
    start_det_d  = 1'b0;
    stop_det_d   = 1'b0;
    nack_det_d   = 1'b0;

    if (rx_pend) first_pend_d = 1'b0;

    // Read byte load: bit7 goes on the wire now, the rest waits in the shifter.
    if (tx_req) begin
      if (load_ok_c) begin
        shift_d   = {tx_data[6:0], 1'b0};
        sda_oe_d  = ~tx_data[7];
        bit_cnt_d = BCNT_W'(7);
      end else begin
        tx_req_d = 1'b1;
      end
    end

    case (state)
      S_IDLE: ;
      S_ADDR: begin
        if (scl_rise_c) begin
          shift_d = shift_in_c;
          if (bit_cnt == '0) begin
            // General call (all-zero address) is never acknowledged.
            if (shift_in_c[7:1] == TARGET_ADDR && shift_in_c[7:1] != 7'h00) begin
              state_d      = S_ACK_ADDR;
              ack_phase_d  = 1'b0;
              busy_d       = 1'b1;
              rw_d         = shift_in_c[0];
              first_pend_d = ~shift_in_c[0];
            end else begin
              state_d = S_WAIT_STOP;
              busy_d  = 1'b0;
            end
          end else begin
            bit_cnt_d = bit_cnt - BCNT_W'(1);
          end
        end
      end
      S_ACK_ADDR: begin
        if (scl_fall_c) begin
          if (!ack_phase) begin
            sda_oe_d    = 1'b1;
            ack_phase_d = 1'b1;
          end else begin
            sda_oe_d    = 1'b0;
            ack_phase_d = 1'b0;
            bit_cnt_d   = BCNT_W'(7);
            if (rw) begin
              state_d  = S_READ;
              tx_req_d = 1'b1;
            end else begin
              state_d = S_WRITE;
            end
          end
        end
      end
      S_WRITE: begin
        if (scl_rise_c) begin
          shift_d = shift_in_c;
          if (bit_cnt == '0) begin
            rx_data_d   = shift_in_c;
            rx_pend_d   = 1'b1;
            state_d     = S_ACK_WR;
            ack_phase_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt - BCNT_W'(1);
          end
        end
      end
      S_ACK_WR: begin
        if (scl_fall_c) begin
          if (!ack_phase) begin
            sda_oe_d    = 1'b1;
            ack_phase_d = 1'b1;
          end else begin
            sda_oe_d    = 1'b0;
            ack_phase_d = 1'b0;
            bit_cnt_d   = BCNT_W'(7);
            state_d     = S_WRITE;
          end
        end
      end
      S_READ: begin
        // bit_cnt counts data bits still to present; the 8th fall frees SDA.
        if (scl_fall_c) begin
          if (bit_cnt == '0) begin
            sda_oe_d    = 1'b0;
            ack_phase_d = 1'b0;
            state_d     = S_ACK_RD;
          end else begin
            sda_oe_d  = ~shift[7];
            shift_d   = {shift[6:0], 1'b0};
            bit_cnt_d = bit_cnt - BCNT_W'(1);
          end
        end
      end
      S_ACK_RD: begin
        if (scl_rise_c) begin
          if (sda_f) begin
            nack_det_d = 1'b1;
            state_d    = S_WAIT_STOP;
          end else begin
            ack_phase_d = 1'b1;
          end
        end else if (scl_fall_c && ack_phase) begin
          ack_phase_d = 1'b0;
          state_d     = S_READ;
          tx_req_d    = 1'b1;
        end
      end
      S_WAIT_STOP: ;
      default: state_d = S_IDLE;
    endcase

    // Bus conditions win in every state and abort any partial byte.
    if (start_c) begin
      state_d     = S_ADDR;
      bit_cnt_d   = BCNT_W'(7);
      ack_phase_d = 1'b0;
      sda_oe_d    = 1'b0;
      tx_req_d    = 1'b0;
      start_det_d = 1'b1;
    end else if (stop_c) begin
      state_d     = S_IDLE;
      ack_phase_d = 1'b0;
      sda_oe_d    = 1'b0;
      tx_req_d    = 1'b0;
      busy_d      = 1'b0;
      stop_det_d  = 1'b1;
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: directed I2C master model with scoreboard queues for write
// bytes (pushed before driving) and read bytes (pushed when served).
module tb_i2c_target;
  localparam int unsigned Q = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic m_scl_lo = 1'b0;
  logic m_sda_lo = 1'b0;
  wire  scl_w, sda_w;
  assign scl_w = m_scl_lo ? 1'b0 : 1'bz;
  assign sda_w = m_sda_lo ? 1'b0 : 1'bz;
  pullup (scl_w);
  pullup (sda_w);

  logic [7:0] rx_data, tx_data;
  logic rx_valid, rx_first, tx_req, tx_valid, busy, rw, start_det, stop_det, nack_det;

  i2c_target #(.TARGET_ADDR(7'h34), .FILTER_LEN(3)) dut (
    .clk(clk), .rst_n(rst_n), .scl(scl_w), .sda(sda_w),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_first(rx_first),
    .tx_req(tx_req), .tx_data(tx_data), .tx_valid(tx_valid),
    .busy(busy), .rw(rw), .start_det(start_det), .stop_det(stop_det), .nack_det(nack_det)
  );

  int tests = 0;
  int fails = 0;
  int start_cnt = 0, stop_cnt = 0, nack_cnt = 0, req_cnt = 0, drove_cnt = 0, stretch_cnt = 0;
  logic tx_req_q = 1'b0;
  logic [8:0] rx_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] rd_bytes[8];
  int rd_idx;
`ifdef I2C_CLK_STRETCH_EN
  int tx_delay = 0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pulse counters and write-byte scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (start_det) start_cnt++;
      if (stop_det) stop_cnt++;
      if (nack_det) nack_cnt++;
      if (tx_req && !tx_req_q) req_cnt++;
      if (!m_sda_lo && sda_w === 1'b0) drove_cnt++;
      if (!m_scl_lo && scl_w === 1'b0) stretch_cnt++;
      if (rx_valid) begin
        if (rx_q.size() == 0) begin
          chk("rx_unexpected", 32'(rx_valid), 32'd0);
        end else begin
          logic [8:0] e;
          e = rx_q.pop_front();
          chk("rx_byte", 32'(rx_data), 32'(e[7:0]));
          chk("rx_first", 32'(rx_first), 32'(e[8]));
        end
      end
    end
    tx_req_q = tx_req;
  end

  // Read-byte responder: tx_data is held valid ahead of each request.
  initial begin
    rd_bytes = '{8'hC3, 8'h5A, 8'h96, 8'h0F, 8'h81, 8'h00, 8'h00, 8'h00};
    rd_idx   = 0;
    tx_data  = rd_bytes[0];
    tx_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && tx_req === 1'b1) begin
`ifdef I2C_CLK_STRETCH_EN
        repeat (tx_delay) @(negedge clk);
        tx_valid = 1'b1;
`endif
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        rd_q.push_back(tx_data);
        rd_idx  = (rd_idx + 1) % 8;
        tx_data = rd_bytes[rd_idx];
      end
    end
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic scl_release();
    int n;
    n = 0;
    m_scl_lo = 1'b0;
    while (scl_w !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("scl_release_timeout", 32'(scl_w), 32'd1);
  endtask

  task automatic xfer_bit(input logic b, output logic r);
    m_sda_lo = ~b;
    wait_q();
    scl_release();
    wait_q();
    r = sda_w;
    wait_q();
    m_scl_lo = 1'b1;
    wait_q();
  endtask

  task automatic start_cond();
    m_sda_lo = 1'b0;
    wait_q();
    scl_release();
    wait_q();
    m_sda_lo = 1'b1;
    wait_q();
    m_scl_lo = 1'b1;
    wait_q();
  endtask

  task automatic stop_cond();
    m_sda_lo = 1'b1;
    wait_q();
    scl_release();
    wait_q();
    m_sda_lo = 1'b0;
    wait_q();
    wait_q();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) xfer_bit(b[i], r);
    xfer_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(1'b1, r);
      d[i] = r;
    end
    xfer_bit(nack, r);
  endtask

  task automatic check_rd(input string tag, input logic [7:0] d);
    logic [8:0] e;
    e = (rd_q.size() != 0) ? {1'b0, rd_q.pop_front()} : 9'h100;
    chk(tag, 32'({1'b0, d}), 32'(e));
  endtask

  initial begin
    logic ack, r;
    logic [7:0] d;
    int s0, p0, n0, q0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rw", 32'(rw), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'h00);
    chk("rst_tx_req", 32'(tx_req), 32'd0);
    chk("rst_pulses", 32'({start_det, stop_det, nack_det, rx_first}), 32'd0);
    chk("rst_sda", 32'(sda_w), 32'd1);
    chk("rst_scl", 32'(scl_w), 32'd1);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // 1: write A5, 3C
    s0 = start_cnt; p0 = stop_cnt;
    rx_q.push_back({1'b1, 8'hA5});
    rx_q.push_back({1'b0, 8'h3C});
    start_cond();
    write_byte(8'h68, ack); chk("t1_ack_addr", 32'(ack), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_rw", 32'(rw), 32'd0);
    write_byte(8'hA5, ack); chk("t1_ack_a5", 32'(ack), 32'd0);
    write_byte(8'h3C, ack); chk("t1_ack_3c", 32'(ack), 32'd0);
    stop_cond();
    chk("t1_rx_left", 32'(rx_q.size()), 32'd0);
    chk("t1_start", 32'(start_cnt - s0), 32'd1);
    chk("t1_stop", 32'(stop_cnt - p0), 32'd1);
    chk("t1_busy_end", 32'(busy), 32'd0);

    // 2: foreign address and general call are ignored, then a match is ACKed
    drove_cnt = 0;
    start_cond();
    write_byte(8'h6A, ack); chk("t2_nack_addr", 32'(ack), 32'd1);
    chk("t2_busy", 32'(busy), 32'd0);
    write_byte(8'h55, ack); chk("t2_nack_data", 32'(ack), 32'd1);
    stop_cond();
    start_cond();
    write_byte(8'h00, ack); chk("t2_gencall", 32'(ack), 32'd1);
    stop_cond();
    chk("t2_sda_never", 32'(drove_cnt), 32'd0);
    start_cond();
    write_byte(8'h68, ack); chk("t2_ack_match", 32'(ack), 32'd0);
    stop_cond();

    // 3: read C3 (ACK), 5A (NACK)
    q0 = req_cnt; n0 = nack_cnt;
    start_cond();
    write_byte(8'h69, ack); chk("t3_ack_addr", 32'(ack), 32'd0);
    chk("t3_rw", 32'(rw), 32'd1);
    read_byte(1'b0, d); check_rd("t3_rd0", d);
    chk("t3_rd0_val", 32'(d), 32'hC3);
    read_byte(1'b1, d); check_rd("t3_rd1", d);
    chk("t3_rd1_val", 32'(d), 32'h5A);
    stop_cond();
    chk("t3_tx_req", 32'(req_cnt - q0), 32'd2);
    chk("t3_nack", 32'(nack_cnt - n0), 32'd1);
    chk("t3_busy_end", 32'(busy), 32'd0);

    // 4: write then repeated START into a read
    s0 = start_cnt;
    rx_q.push_back({1'b1, 8'h11});
    start_cond();
    write_byte(8'h68, ack); chk("t4_ack_w", 32'(ack), 32'd0);
    write_byte(8'h11, ack); chk("t4_ack_11", 32'(ack), 32'd0);
    chk("t4_rw0", 32'(rw), 32'd0);
    start_cond();
    chk("t4_busy_restart", 32'(busy), 32'd1);
    write_byte(8'h69, ack); chk("t4_ack_r", 32'(ack), 32'd0);
    chk("t4_rw1", 32'(rw), 32'd1);
    chk("t4_busy", 32'(busy), 32'd1);
    read_byte(1'b1, d); check_rd("t4_rd", d);
    stop_cond();
    chk("t4_start", 32'(start_cnt - s0), 32'd2);
    chk("t4_rx_left", 32'(rx_q.size()), 32'd0);

    // 5: sub-filter glitches, then reset mid-read
    s0 = start_cnt; p0 = stop_cnt;
    m_sda_lo = 1'b1; @(negedge clk); m_sda_lo = 1'b0;
    repeat (20) @(negedge clk);
    m_sda_lo = 1'b1; repeat (2) @(negedge clk); m_sda_lo = 1'b0;
    repeat (20) @(negedge clk);
    chk("t5_glitch_start", 32'(start_cnt - s0), 32'd0);
    rx_q.push_back({1'b1, 8'h12});
    start_cond();
    write_byte(8'h68, ack); chk("t5_ack", 32'(ack), 32'd0);
    m_sda_lo = 1'b1;
    wait_q(); scl_release(); wait_q();
    m_sda_lo = 1'b0; repeat (2) @(negedge clk); m_sda_lo = 1'b1;
    wait_q(); m_scl_lo = 1'b1; wait_q();
    for (int i = 6; i >= 0; i--) begin
      logic [7:0] b;
      b = 8'h12;
      xfer_bit(b[i], r);
    end
    xfer_bit(1'b1, ack); chk("t5_ack_12", 32'(ack), 32'd0);
    chk("t5_glitch_stop", 32'(stop_cnt - p0), 32'd0);
    chk("t5_rx_left", 32'(rx_q.size()), 32'd0);
    start_cond();
    write_byte(8'h69, ack); chk("t5_ack_rd", 32'(ack), 32'd0);
    xfer_bit(1'b1, r);
    xfer_bit(1'b1, r);
    chk("t5_read_drive", 32'(sda_w), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_sda", 32'(sda_w), 32'd1);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    void'(rd_q.pop_front());
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    scl_release();
    repeat (20) @(negedge clk);

    // 6: clock stretching on a delayed tx_valid
    stretch_cnt = 0;
`ifdef I2C_CLK_STRETCH_EN
    tx_delay = 500;
`endif
    start_cond();
    write_byte(8'h69, ack); chk("t6_ack", 32'(ack), 32'd0);
    read_byte(1'b1, d); check_rd("t6_rd", d);
    chk("t6_rd_val", 32'(d), 32'h81);
    stop_cond();
`ifdef I2C_CLK_STRETCH_EN
    chk("t6_stretch_len", 32'(stretch_cnt >= 480), 32'd1);
    tx_delay = 0;
`else
    chk("t6_no_stretch", 32'(stretch_cnt), 32'd0);
`endif
    chk("t6_rd_left", 32'(rd_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

endmodule
